// File: rtl/lia_iq_modulator_pkg.sv
// Shared constants and elaboration-time helpers for the I/Q modulator slice.
package lia_iq_modulator_pkg;

    localparam int I_MSB = 31;
    localparam int Q_MSB = 15;
    localparam real PI = 3.14159265358979323846;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // One full-wave ROM entry: round(peak * sin(2*pi*k / 2^phase_bits)); int'() of a real rounds to nearest.
    function automatic int sine_rom_init(input int k, input int phase_bits, input int amp_bits);
        real peak;
        real angle;
        peak  = real'((1 << (amp_bits - 1)) - 1);
        angle = 2.0 * PI * real'(k) / real'(1 << phase_bits);
        return int'(peak * $sin(angle));
    endfunction

endpackage

// File: rtl/lia_iq_modulator_cic.sv
// One channel of the N-stage CIC interpolator (combs at strobe rate, integrators at clock rate).
module cic_interp_lia
    import lia_iq_modulator_pkg::*;
#(
    parameter int R        = 16,
    parameter int N        = 2,
    parameter int IQ_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       strobe,
    input  logic signed [IQ_WIDTH-1:0] din,
    output logic signed [IQ_WIDTH-1:0] dout
);

    localparam int SHIFT = clog2(R);
    localparam int W     = IQ_WIDTH + N * SHIFT;

    logic signed [W-1:0] comb_in [N+1];
    logic signed [W-1:0] delay   [N];
    logic signed [W-1:0] integ   [N];
    logic signed [W-1:0] comb_out;
    logic signed [W-1:0] stuff;
    logic                strobe_d;

    // Comb chain is combinational between strobes; only its delays and final result are registered.
    always_comb begin
        comb_in[0] = W'(din);
        for (int unsigned k = 0; k < N; k++) begin
            comb_in[k+1] = comb_in[k] - delay[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) begin
                delay[k] <= '0;
                integ[k] <= '0;
            end
            comb_out <= '0;
            stuff    <= '0;
            strobe_d <= 1'b0;
        end else begin
            if (strobe) begin
                for (int unsigned k = 0; k < N; k++) begin
                    delay[k] <= comb_in[k];
                end
                comb_out <= comb_in[N];
            end
            strobe_d <= strobe;
            stuff    <= strobe_d ? comb_out : '0;
            integ[0] <= integ[0] + stuff;
            for (int unsigned k = 1; k < N; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    assign dout = IQ_WIDTH'(integ[N-1] >>> ((N - 1) * SHIFT));

endmodule

// File: rtl/lia_iq_modulator.sv
// I/Q upconverter: CIC-interpolated baseband mixed onto an NCO carrier, out = I*cos - Q*sin.
module lia_iq_modulator
    import lia_iq_modulator_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ACCUM_WIDTH      = 32,
    parameter int PHASE_BITS       = 10,
    parameter int AMPLITUDE_BITS   = 14,
    parameter int IQ_WIDTH         = 16,
    parameter int OUTPUT_WIDTH     = 14,
    parameter int R                = 16,
    parameter int N                = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_IQ_tdata,
    input  logic                        S_AXIS_IQ_tvalid,
    output logic                        S_AXIS_IQ_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_FREQ_tdata,
    input  logic                        S_AXIS_FREQ_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
    output logic                        M_AXIS_OUT_tvalid,
    output logic                        underflow,
    input  logic                        underflow_clr
);

    localparam int CNT_W = clog2(R);
    localparam int DEPTH = 2 ** PHASE_BITS;
    localparam int PW    = IQ_WIDTH + AMPLITUDE_BITS + 1;

    logic [CNT_W-1:0]                 rate_cnt;
    logic                             strobe;
    logic [ACCUM_WIDTH-1:0]           acc;
    logic [ACCUM_WIDTH-1:0]           freq_word;
    logic [PHASE_BITS-1:0]            sin_idx;
    logic [PHASE_BITS-1:0]            cos_idx;
    logic signed [AMPLITUDE_BITS-1:0] sine_rom [DEPTH];
    logic signed [AMPLITUDE_BITS-1:0] sin_q;
    logic signed [AMPLITUDE_BITS-1:0] cos_q;
    logic signed [IQ_WIDTH-1:0]       i_in;
    logic signed [IQ_WIDTH-1:0]       q_in;
    logic signed [IQ_WIDTH-1:0]       i_cic;
    logic signed [IQ_WIDTH-1:0]       q_cic;
    logic signed [PW-1:0]             mix_full;
    logic signed [PW-1:0]             mix_shift;
    logic signed [OUTPUT_WIDTH-1:0]   mix_sat;
    logic signed [OUTPUT_WIDTH-1:0]   out_q;
    logic                             out_valid;

    assign strobe           = (rate_cnt == CNT_W'(R - 1));
    assign S_AXIS_IQ_tready = strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_cnt  <= '0;
            underflow <= 1'b0;
        end else begin
            rate_cnt <= strobe ? '0 : rate_cnt + CNT_W'(1);
            if (strobe && !S_AXIS_IQ_tvalid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    // A missing sample on strobe is fed to the combs as zero.
    assign i_in = S_AXIS_IQ_tvalid ? S_AXIS_IQ_tdata[I_MSB -: IQ_WIDTH] : '0;
    assign q_in = S_AXIS_IQ_tvalid ? S_AXIS_IQ_tdata[Q_MSB -: IQ_WIDTH] : '0;

    cic_interp_lia #(.R(R), .N(N), .IQ_WIDTH(IQ_WIDTH)) u_cic_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (strobe),
        .din    (i_in),
        .dout   (i_cic)
    );

    cic_interp_lia #(.R(R), .N(N), .IQ_WIDTH(IQ_WIDTH)) u_cic_q (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (strobe),
        .din    (q_in),
        .dout   (q_cic)
    );

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign sine_rom[k] = AMPLITUDE_BITS'(sine_rom_init(k, PHASE_BITS, AMPLITUDE_BITS));
    end

    assign sin_idx = acc[ACCUM_WIDTH-1 -: PHASE_BITS];
    assign cos_idx = sin_idx + PHASE_BITS'(2 ** (PHASE_BITS - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_word <= '0;
            acc       <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
        end else begin
            if (S_AXIS_FREQ_tvalid) begin
                freq_word <= S_AXIS_FREQ_tdata[ACCUM_WIDTH-1:0];
            end
            acc   <= acc + freq_word;
            sin_q <= sine_rom[sin_idx];
            cos_q <= sine_rom[cos_idx];
        end
    end

    always_comb begin
        mix_full  = PW'(i_cic) * PW'(cos_q) - PW'(q_cic) * PW'(sin_q);
        mix_shift = mix_full >>> (AMPLITUDE_BITS - 1);
        mix_sat   = mix_shift[OUTPUT_WIDTH-1:0];
        if (mix_shift > PW'(2 ** (OUTPUT_WIDTH - 1) - 1)) begin
            mix_sat = {1'b0, {(OUTPUT_WIDTH - 1){1'b1}}};
        end else if (mix_shift < -PW'(2 ** (OUTPUT_WIDTH - 1))) begin
            mix_sat = {1'b1, {(OUTPUT_WIDTH - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_q     <= mix_sat;
            out_valid <= 1'b1;
        end
    end

    assign M_AXIS_OUT_tdata  = {{(AXIS_TDATA_WIDTH - OUTPUT_WIDTH){out_q[OUTPUT_WIDTH-1]}}, out_q};
    assign M_AXIS_OUT_tvalid = out_valid;

endmodule

// File: tb/tb_lia_iq_modulator.sv
// Directed bench for lia_iq_modulator (R=16, N=2, 14-bit NCO and output).
// Latency: counting the edge that accepts a sample as edge 1, the output register
// first reflects it after edge N+3 = 5 (comb reg, stuffer, 2 integrators, mixer reg).
module tb_lia_iq_modulator;

    logic        clk;
    logic        rst_n;
    logic [31:0] iq_tdata;
    logic        iq_tvalid;
    logic        iq_tready;
    logic [31:0] freq_tdata;
    logic        freq_tvalid;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        underflow;
    logic        underflow_clr;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    lia_iq_modulator #(
        .AXIS_TDATA_WIDTH (32),
        .ACCUM_WIDTH      (32),
        .PHASE_BITS       (10),
        .AMPLITUDE_BITS   (14),
        .IQ_WIDTH         (16),
        .OUTPUT_WIDTH     (14),
        .R                (16),
        .N                (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .S_AXIS_IQ_tdata    (iq_tdata),
        .S_AXIS_IQ_tvalid   (iq_tvalid),
        .S_AXIS_IQ_tready   (iq_tready),
        .S_AXIS_FREQ_tdata  (freq_tdata),
        .S_AXIS_FREQ_tvalid (freq_tvalid),
        .M_AXIS_OUT_tdata   (out_tdata),
        .M_AXIS_OUT_tvalid  (out_tvalid),
        .underflow          (underflow),
        .underflow_clr      (underflow_clr)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int out_val();
        return $signed(out_tdata);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int i_val, input int q_val);
        rst_n         = 1'b0;
        iq_tdata      = {i_val[15:0], q_val[15:0]};
        iq_tvalid     = 1'b1;
        freq_tvalid   = 1'b0;
        underflow_clr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic set_freq(input logic [31:0] f);
        freq_tdata  = f;
        freq_tvalid = 1'b1;
        tick();
        freq_tvalid = 1'b0;
    endtask

    // Ticks until tready is seen; n is the number of ticks taken.
    task automatic wait_tready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!iq_tready && n < 64);
        if (!iq_tready) check_vec("tready_timeout", 0, 1);
    endtask

    // Finds a0 within 8 samples, then checks the next three; off is cycle phase mod 4 of a0.
    task automatic check_quad(input string tag, input int a0, input int a1, input int a2,
                              input int a3, output int off);
        int found;
        found = 0;
        off   = -1;
        for (int i = 0; i < 8; i++) begin
            if (out_val() == a0) begin
                found = 1;
                off   = cyc % 4;
                break;
            end
            tick();
        end
        check_vec({tag, "_find"}, found, 1);
        if (found == 1) begin
            tick(); check_vec({tag, "_s1"}, out_val(), a1);
            tick(); check_vec({tag, "_s2"}, out_val(), a2);
            tick(); check_vec({tag, "_s3"}, out_val(), a3);
        end
    endtask

    initial begin
        int n;
        int edge_at;
        int v;
        int i_off;
        int q_off;
        int vmax;
        int vmin;

        // Reset with random inputs
        rst_n         = 1'b0;
        iq_tdata      = $urandom;
        iq_tvalid     = 1'b1;
        freq_tdata    = $urandom;
        freq_tvalid   = 1'b1;
        underflow_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            iq_tdata      = $urandom;
            iq_tvalid     = 1'($urandom);
            freq_tdata    = $urandom;
            underflow_clr = 1'($urandom);
        end
        check_vec("rst_tdata", out_val(), 0);
        check_vec("rst_tready", int'(iq_tready), 0);
        check_vec("rst_tvalid", int'(out_tvalid), 0);
        check_vec("rst_underflow", int'(underflow), 0);

        // DC carrier, I=1000: first tready after 15 ticks, latency, settled value
        do_reset(1000, 0);
        wait_tready(n);
        check_vec("tready_first", n, 15);
        check_vec("tvalid_after_rst", int'(out_tvalid), 1);
        edge_at = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (edge_at == 0 && out_val() != 0) begin
                edge_at = e;
                v       = out_val();
            end
        end
        check_vec("latency_edges", edge_at, 5);
        check_vec("latency_first_val", v, 61);
        repeat (60) tick();
        for (int i = 0; i < 4; i++) begin
            check_vec("dc_1000", out_val(), 999);
            tick();
        end
        check_vec("dc_underflow", int'(underflow), 0);
        wait_tready(n);
        wait_tready(n);
        check_vec("tready_period_a", n, 16);
        wait_tready(n);
        check_vec("tready_period_b", n, 16);

        // Underflow: sticky set, clear, set wins over clear
        iq_tvalid = 1'b0;
        tick();
        iq_tvalid = 1'b1;
        check_vec("uf_set", int'(underflow), 1);
        repeat (20) tick();
        check_vec("uf_sticky", int'(underflow), 1);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        check_vec("uf_clr", int'(underflow), 0);
        wait_tready(n);
        iq_tvalid     = 1'b0;
        underflow_clr = 1'b1;
        tick();
        iq_tvalid     = 1'b1;
        underflow_clr = 1'b0;
        check_vec("uf_set_wins", int'(underflow), 1);

        // fs/4 carrier, I only: 999, 0, -1000, 0
        do_reset(1000, 0);
        set_freq(32'h4000_0000);
        repeat (80) tick();
        check_quad("fs4_i", 999, 0, -1000, 0, i_off);

        // fs/4 carrier, Q only: -Q*sin leads the I pattern by one clock
        do_reset(0, 1000);
        set_freq(32'h4000_0000);
        repeat (80) tick();
        check_quad("fs4_q", 999, 0, -1000, 0, q_off);
        check_vec("fs4_q_shift", q_off, (i_off + 3) % 4);

        // Saturation: full-scale I=Q at fs/8 must clamp, never wrap
        do_reset(32767, 32767);
        set_freq(32'h2000_0000);
        repeat (80) tick();
        vmax = -100000;
        vmin = 100000;
        for (int i = 0; i < 16; i++) begin
            v = out_val();
            check_vec("sat_set", int'(v == 8191 || v == 0 || v == -8192), 1);
            if (v > vmax) vmax = v;
            if (v < vmin) vmin = v;
            tick();
        end
        check_vec("sat_max", vmax, 8191);
        check_vec("sat_min", vmin, -8192);

        // Async reset between edges, then re-settle at DC 500
        do_reset(1000, 0);
        repeat (60) tick();
        check_vec("mid_pre", out_val(), 999);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_tdata", out_val(), 0);
        check_vec("mid_rst_tvalid", int'(out_tvalid), 0);
        check_vec("mid_rst_tready", int'(iq_tready), 0);
        do_reset(500, 0);
        repeat (80) tick();
        for (int i = 0; i < 3; i++) begin
            check_vec("dc_500", out_val(), 499);
            tick();
        end
        check_vec("dc_500_underflow", int'(underflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lia_iq_modulator.md
Name: lia_iq_modulator

Overview:
- Transmit-side counterpart to the lock-in demodulator: accepts baseband I/Q samples at the decimated rate and interpolates them by R with an N-stage CIC.
- Mixes up onto an internal NCO carrier: out = I·cos − Q·sin.
- Drives a DAC channel or loops back into the lock-in chain for self-test; 125 MHz system clock domain.

Parameters:
- AXIS_TDATA_WIDTH, 32, width of AXIS data buses.
- ACCUM_WIDTH, 32, phase accumulator width.
- PHASE_BITS, 10, LUT address width (full-wave sine ROM, 2^PHASE_BITS entries).
- AMPLITUDE_BITS, 14, signed NCO amplitude width; peak = 2^(AMPLITUDE_BITS-1)−1.
- IQ_WIDTH, 16, signed width of each of I and Q.
- OUTPUT_WIDTH, 14, signed modulated output width.
- R, 16, interpolation ratio; power of two, ≥2.
- N, 2, CIC order, 1..4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- S_AXIS_IQ_tdata  in  AXIS_TDATA_WIDTH  [31:16] I, [15:0] Q, signed.
- S_AXIS_IQ_tvalid  in  1  sample valid.
- S_AXIS_IQ_tready  out  1  high for one cycle every R clocks.
- S_AXIS_FREQ_tdata  in  AXIS_TDATA_WIDTH  carrier frequency word, low ACCUM_WIDTH bits.
- S_AXIS_FREQ_tvalid  in  1  latch frequency word.
- M_AXIS_OUT_tdata  out  AXIS_TDATA_WIDTH  modulated output, sign-extended from OUTPUT_WIDTH.
- M_AXIS_OUT_tvalid  out  1  constant 1 after reset release.
- underflow  out  1  sticky: a strobe occurred without tvalid.
- underflow_clr  in  1  synchronous clear of underflow.

Behaviour:
- Reset (rst_n=0, async): rate counter, phase accumulator, frequency word, combs, integrators and output register = 0. tready=0, tvalid=0, underflow=0.
- Rate counter counts 0..R−1 and wraps. strobe = (count==R−1). tready = strobe.
- Handshake on strobe:
  - tvalid=1: capture I/Q into comb stage 0.
  - tvalid=0: feed zeros and set underflow.
  - tvalid outside strobe is ignored; no data is accepted.
- underflow_clr and a new underflow in the same cycle: set wins.
- Frequency word: freq_word <= S_AXIS_FREQ_tdata when S_AXIS_FREQ_tvalid. Takes effect on the next accumulator update. Accumulator acc <= acc + freq_word every clock, wrapping modulo 2^ACCUM_WIDTH.
- LUT addressing:
  - sin index = acc[MSB -: PHASE_BITS].
  - cos index = sin index + 2^(PHASE_BITS−2), wrapping.
  - ROM is registered, 1-cycle latency.
- CIC, per I and Q channel, internal width W = IQ_WIDTH + N·log2(R):
  - N combs update only on strobe: c_k = x_k − x_k(prev).
  - Zero-stuffer: integrator-1 input = comb_N output on the cycle after strobe, else 0.
  - N integrators accumulate every clock, modulo 2^W.
  - Gain R^(N−1) is removed by arithmetic right shift of (N−1)·log2(R), giving IQ_WIDTH.
- Mixer:
  - p = I·cos − Q·sin, full precision.
  - Shift right by AMPLITUDE_BITS−1.
  - Saturate to OUTPUT_WIDTH at ±(2^(OUTPUT_WIDTH−1)−1 / −2^(OUTPUT_WIDTH−1)).
  - Result is registered.
- Latency from accepted sample to first output change: N+3 clocks (combs, stuffer, integrator, mixer register). This is fixed and must be documented in the testbench.
- DC gain: a constant input settles to exactly the input value after N·R clocks, with no drift.
- Reset mid-operation clears all state and the next output is 0. Changing freq_word mid-stream is phase-continuous, with no accumulator reset.

Decomposition:
- Shared package holds:
  - IQ field offsets (I_MSB=31, Q_MSB=15).
  - Helper function clog2.
  - Sine ROM init function, which rounds amplitude·sin(2πk/2^PHASE_BITS).
- Sub-module cic_interp_lia: one channel, parameters R, N, IQ_WIDTH; ports clk, rst_n, strobe, din, dout. Instantiated twice.
- NCO accumulator and ROM stay inline.

Test Plan:
- Reset: hold rst_n=0 with random inputs → tdata=0, tready=0, tvalid=0, underflow=0. Release → tready pulses exactly every 16 clocks.
- DC carrier: freq_word=0, I=1000, Q=0 always valid → output settles to 1000·8191/8192 → 999 or 1000 (±1 LSB) within N·R+N+3 clocks; underflow stays 0.
- fs/4 carrier: freq_word=2^30, I=1000, Q=0 → steady-state output repeats 999, 0, −999, 0 (±1). With I=0, Q=1000 the same sequence is shifted by one clock, sign per −sin.
- Saturation: OUTPUT_WIDTH=14, I=Q=32767, freq_word=2^29 → output clamps at 8191 / −8192 with no wrap.
- Underflow: drop tvalid for one strobe → underflow=1 and stays set. Pulse underflow_clr → 0. Simultaneous clr and new underflow → 1.
- Async reset mid-stream: assert rst_n low between clock edges → outputs 0 immediately. After release, a DC input of 500 re-settles to 500.
